// File: rtl/display_scheduler.sv
// Two-digit seven-segment time-multiplexer with dead-time blanking and
// frame-aligned double-buffered digit updates.
module display_scheduler #(
    parameter int SHOW_CYC  = 48000,
    parameter int BLANK_CYC = 480
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       upd_valid,
    input  logic [7:0] upd_data,
    output logic       upd_ready,
    output logic [6:0] seg,
    output logic       disL,
    output logic       disR,
    output logic       frame_tick
);

    localparam int MAXC = (SHOW_CYC > BLANK_CYC) ? SHOW_CYC : BLANK_CYC;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [CW-1:0] SHOW_LD  = CW'(SHOW_CYC - 1);
    localparam logic [CW-1:0] BLANK_LD = CW'(BLANK_CYC - 1);

    typedef enum logic [1:0] {
        BLANK_L = 2'd0,
        SHOW_L  = 2'd1,
        BLANK_R = 2'd2,
        SHOW_R  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    active_q, pending_q;
    logic          full_q, tick_q;
    logic          boundary;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'b1000000;
            4'h1: hex7 = 7'b1111001;
            4'h2: hex7 = 7'b0100100;
            4'h3: hex7 = 7'b0110000;
            4'h4: hex7 = 7'b0011001;
            4'h5: hex7 = 7'b0010010;
            4'h6: hex7 = 7'b0000010;
            4'h7: hex7 = 7'b1111000;
            4'h8: hex7 = 7'b0000000;
            4'h9: hex7 = 7'b0010000;
            4'hA: hex7 = 7'b0001000;
            4'hB: hex7 = 7'b0000011;
            4'hC: hex7 = 7'b1000110;
            4'hD: hex7 = 7'b0100001;
            4'hE: hex7 = 7'b0000110;
            default: hex7 = 7'b0001110;
        endcase
    endfunction

    // The down-counter holds the cycles remaining in the current state minus one.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == '0) begin
            case (state_q)
                BLANK_L: begin state_d = SHOW_L;  cnt_d = SHOW_LD;  end
                SHOW_L:  begin state_d = BLANK_R; cnt_d = BLANK_LD; end
                BLANK_R: begin state_d = SHOW_R;  cnt_d = SHOW_LD;  end
                default: begin state_d = BLANK_L; cnt_d = BLANK_LD; end
            endcase
        end
    end

    assign boundary = (state_q == SHOW_R) && (cnt_q == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= BLANK_L;
            cnt_q   <= BLANK_LD;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Swap only consumes an update that was already pending before the boundary;
    // one accepted on the boundary edge itself waits a full frame.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q  <= 8'h00;
            pending_q <= 8'h00;
            full_q    <= 1'b0;
            tick_q    <= 1'b0;
        end else begin
            tick_q <= boundary;
            if (boundary && full_q) begin
                active_q <= pending_q;
                full_q   <= 1'b0;
            end
            if (upd_valid && !full_q) begin
                pending_q <= upd_data;
                full_q    <= 1'b1;
            end
        end
    end

    always_comb begin
        seg  = 7'h7F;
        disL = 1'b0;
        disR = 1'b0;
        case (state_q)
            SHOW_L: begin disL = 1'b1; seg = hex7(active_q[7:4]); end
            SHOW_R: begin disR = 1'b1; seg = hex7(active_q[3:0]); end
            default: ;
        endcase
    end

    assign upd_ready  = ~full_q;
    assign frame_tick = tick_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Directed and randomized checks of display_scheduler against a frame-position
// reference model (SHOW_CYC=4, BLANK_CYC=2, 12-cycle frame).
module tb_display_scheduler;

    localparam int S = 4;
    localparam int B = 2;
    localparam int F = 2 * (S + B);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       upd_valid = 1'b0;
    logic [7:0] upd_data = 8'h00;
    logic       upd_ready;
    logic [6:0] seg;
    logic       disL;
    logic       disR;
    logic       frame_tick;

    int checks = 0;
    int failures = 0;

    int         cyc;
    logic [7:0] mActive;
    logic [7:0] mPending;
    logic       mFull;

    logic [6:0] hexTab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    display_scheduler #(.SHOW_CYC(S), .BLANK_CYC(B)) dut (
        .clk        (clk),
        .reset      (reset),
        .upd_valid  (upd_valid),
        .upd_data   (upd_data),
        .upd_ready  (upd_ready),
        .seg        (seg),
        .disL       (disL),
        .disR       (disR),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, observed, expected);
        end
    endtask

    // Reset is applied while upd_valid is high to show it overrides a handshake.
    task automatic doReset(input int n);
        reset = 1'b1;
        upd_valid = 1'b1;
        upd_data = 8'hEE;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
        checkOutput("rst_seg", {1'b0, seg}, 8'h7F);
        checkOutput("rst_disL", {7'd0, disL}, 8'h00);
        checkOutput("rst_disR", {7'd0, disR}, 8'h00);
        checkOutput("rst_tick", {7'd0, frame_tick}, 8'h00);
        checkOutput("rst_ready", {7'd0, upd_ready}, 8'h01);
        reset = 1'b0;
        upd_valid = 1'b0;
        cyc = 0;
        mActive = 8'h00;
        mPending = 8'h00;
        mFull = 1'b0;
    endtask

    // One cycle: drive inputs, compare against the frame-position model, advance.
    task automatic applyStimulus(input logic v, input logic [7:0] d);
        int ph;
        logic expL, expR, expTick, acc, bnd;
        logic [6:0] expSeg;
        upd_valid = v;
        upd_data = d;
        ph = cyc % F;
        expL = (ph >= B) && (ph < B + S);
        expR = (ph >= 2 * B + S);
        expSeg = expL ? hexTab[mActive[7:4]] : (expR ? hexTab[mActive[3:0]] : 7'h7F);
        expTick = (cyc >= F) && (ph == 0);
        checkOutput("seg", {1'b0, seg}, {1'b0, expSeg});
        checkOutput("disL", {7'd0, disL}, {7'd0, expL});
        checkOutput("disR", {7'd0, disR}, {7'd0, expR});
        checkOutput("frame_tick", {7'd0, frame_tick}, {7'd0, expTick});
        checkOutput("upd_ready", {7'd0, upd_ready}, {7'd0, ~mFull});
        checkOutput("exclusive", {7'd0, disL & disR}, 8'h00);
        acc = v && !mFull;
        bnd = (ph == F - 1);
        @(posedge clk);
        #1;
        if (bnd && mFull) begin
            mActive = mPending;
            mFull = 1'b0;
        end
        if (acc) begin
            mPending = d;
            mFull = 1'b1;
        end
        cyc++;
    endtask

    task automatic idleTo(input int target);
        while (cyc < target) applyStimulus(1'b0, 8'h00);
    endtask

    initial begin
        cyc = 0;
        mActive = 8'h00;
        mPending = 8'h00;
        mFull = 1'b0;

        // Reset and idle: 0/0 shown, first tick at cycle 12.
        doReset(3);
        idleTo(2 * F);

        // Update mid-frame with 8F at cycle 3.
        doReset(1);
        idleTo(3);
        applyStimulus(1'b1, 8'h8F);
        idleTo(3 * F);

        // Buffer full: 12 accepted, 34 refused until the boundary frees the buffer.
        doReset(1);
        idleTo(1);
        applyStimulus(1'b1, 8'h12);
        while (cyc <= F) applyStimulus(1'b1, 8'h34);
        idleTo(3 * F + 1);

        // Boundary collision: A1 offered exactly on the frame-boundary edge.
        doReset(1);
        idleTo(F - 1);
        applyStimulus(1'b1, 8'hA1);
        idleTo(3 * F);

        // Reset during SHOW_R with 12 active and 55 pending.
        doReset(1);
        idleTo(1);
        applyStimulus(1'b1, 8'h12);
        idleTo(F + 1);
        applyStimulus(1'b1, 8'h55);
        idleTo(F + 2 * B + S + 1);
        doReset(1);
        idleTo(2 * F + 1);

        // Random update stream over ten frames.
        doReset(2);
        for (int i = 0; i < 10 * F; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
